// File: rtl/mips_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit.
package mips_pkg;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10
  } md_state_t;

  localparam int MD_ITERS = 32;

endpackage

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit writing HI/LO; one shift-add or restoring step per cycle.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_t          state, state_nxt;
  md_op_t             op_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0]   mb;
  logic               sa, sb;

  logic               is_div, sgn_op, sa_in, sb_in, div0;
  logic [WIDTH-1:0]   mag_a, mag_b, quo, rem;
  logic [WIDTH:0]     addsub;
  logic [2*WIDTH-1:0] prod;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_d(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  // Operand capture: magnitudes and sign flags for the signed ops
  always_comb begin
    sgn_op = (md_op_t'(op) == MD_MULT) || (md_op_t'(op) == MD_DIV);
    sa_in  = sgn_op & OperandA[WIDTH-1];
    sb_in  = sgn_op & OperandB[WIDTH-1];
    mag_a  = sa_in ? neg_w(OperandA) : OperandA;
    mag_b  = sb_in ? neg_w(OperandB) : OperandB;
  end

  // Shared 33-bit adder: shift-add for multiply, restoring subtract for divide.
  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
  always_comb begin
    is_div  = (op_q == MD_DIV) || (op_q == MD_DIVU);
    addsub  = '0;
    acc_nxt = acc;
    if (is_div) begin
      addsub = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mb};
      if (!addsub[WIDTH])
        acc_nxt = {addsub[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      addsub  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mb} : '0);
      acc_nxt = {addsub, acc[WIDTH-1:1]};
    end
  end

  // Sign fix; a zero divisor leaves the all-ones quotient untouched and the
  // remainder (|A| re-signed) reproduces the dividend.
  always_comb begin
    div0 = (mb == '0);
    prod = (sa ^ sb) ? neg_d(acc) : acc;
    quo  = ((sa ^ sb) && !div0) ? neg_w(acc[WIDTH-1:0]) : acc[WIDTH-1:0];
    rem  = sa ? neg_w(acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = CALC;
      CALC:    if (cnt == CW'(MD_ITERS - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
      cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (hi_we) hi <= wdata;
          if (lo_we) lo <= wdata;
          if (start) begin
            op_q <= md_op_t'(op);
            acc  <= {{WIDTH{1'b0}}, mag_a};
            mb   <= mag_b;
            sa   <= sa_in;
            sb   <= sb_in;
            cnt  <= '0;
          end
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt + CW'(1);
        end
        FIX: begin
          hi   <= is_div ? rem : prod[2*WIDTH-1:WIDTH];
          lo   <= is_div ? quo : prod[WIDTH-1:0];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
